capture_seq: RTL
================

Name: capture_seq

Overview:
Parametrised next-generation capture sequencer for the logic-analyzer sample RAMs.
- Writes a circular buffer of ENTRIES samples across NCH channel RAMs with a per-channel enable mask.
- Arms only after the pre-trigger region is filled, then counts post-trigger samples and stops.
- Reports the trigger address and the oldest-sample address so readout can unroll the ring.
- Sits between the capture/trigger logic and cmd_cfg (run, capture_done, set_capture_done).

Parameters:
ENTRIES, 384, depth of each channel RAM in samples.
AW, $clog2(ENTRIES), RAM address width.
NCH, 5, number of channel RAMs driven.
TPW, 16, width of the trigger-position (post-trigger count) field.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
run  in  1  capture enable from cmd_cfg; deassert aborts.
capture_done  in  1  done flag from cmd_cfg; host clears it to re-enable.
wrt_smpl  in  1  one-cycle sample strobe from capture logic.
triggered  in  1  trigger event from trigger logic; qualified by armed.
trig_pos  in  TPW  number of post-trigger samples to store.
ch_en  in  NCH  per-channel write mask.
we  out  NCH  per-channel RAM write enables.
waddr  out  AW  shared RAM write address.
armed  out  1  pre-trigger region full; trigger accepted.
set_capture_done  out  1  one-cycle pulse to cmd_cfg.
trig_addr  out  AW  address of first post-trigger sample.
rd_start  out  AW  address of oldest valid sample after done.
busy  out  1  high in any state except IDLE and DONE.

Behaviour:
- Reset: state IDLE; waddr, trig_addr, rd_start = 0; we = 0; armed, set_capture_done, busy = 0.
- Position clamp: tp_eff = min(trig_pos, ENTRIES-1), computed in TPW bits. Pre-trigger target pre_n = ENTRIES - tp_eff.
- States: IDLE, PRE, ARMED, POST, DONE.
- IDLE:
  - On run=1 and capture_done=0: clear smpl_cnt, trig_cnt and waddr, then go to PRE.
  - Otherwise stay in IDLE.
- Sample write (PRE/ARMED/POST):
  - On wrt_smpl, we = ch_en combinationally in the same cycle; all other cycles we = 0.
  - waddr advances on the next edge; ENTRIES-1 wraps to 0.
- PRE:
  - Each write increments smpl_cnt.
  - When a write brings smpl_cnt to pre_n: armed <= 1 on that edge, and go to ARMED.
- ARMED:
  - Writes continue and the ring keeps wrapping.
  - triggered=1 latches trig_addr = waddr in that cycle.
  - If wrt_smpl is also high that cycle, the written sample counts as post-trigger sample 1.
  - tp_eff=0: go straight to DONE with set_capture_done; no sample is written for the trigger cycle.
  - Otherwise go to POST.
  - triggered is ignored in PRE and POST.
- POST:
  - Each write increments trig_cnt (16-bit).
  - On the write that makes trig_cnt == tp_eff: set_capture_done = 1 for one cycle, armed <= 0, rd_start <= waddr+1 (wrapped), go to DONE.
- DONE:
  - Hold outputs; we = 0.
  - When capture_done=0, return to IDLE.
- Abort: run=0 in PRE/ARMED/POST forces IDLE next edge; armed <= 0; no set_capture_done pulse; trig_addr and rd_start keep their old values.
- set_capture_done: combinational decode of the FSM, never high for more than one cycle.
- Counters: smpl_cnt saturates at pre_n; no counter overflows, because tp_eff < ENTRIES ≤ 2^TPW.

Optional Feature:
CAPTURE_AUTO_REARM_EN.
- Defined: adds input auto_rearm (1 bit). In DONE, when capture_done falls and auto_rearm=1 and run=1, go directly to PRE with counters and waddr cleared.
- Undefined: port absent; DONE always returns to IDLE.

Decomposition:
- Package capture_pkg: state enum cap_state_t, and a wrap-increment function sized by AW.
- Sub-module ring_addr_ctr: AW-bit counter with clear, increment, and wrap at ENTRIES-1. Used for waddr; its wrapped +1 also computes rd_start.

Test Plan:
- ENTRIES=384, trig_pos=128, wrt_smpl every cycle, triggered at sample 300 → armed after sample 256; trig_addr=299; set_capture_done pulse after 128 post samples; rd_start=(299+128)%384=43.
- trig_pos=0, trigger while ARMED → DONE with zero post writes; waddr unchanged; set_capture_done pulse.
- trig_pos=500 → clamped to 383; armed after exactly 1 sample.
- triggered pulsed during PRE → ignored, armed stays 0; later trigger accepted normally.
- run dropped mid-POST → IDLE next cycle; no done pulse; armed=0; we=0.
- ch_en=5'b10101 → we toggles only on channels 0, 2, 4 on wrt_smpl cycles; async reset mid-capture → all outputs 0 immediately.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture sequencer (capture_seq, ring_addr_ctr).
package capture_pkg;

    localparam int CAP_AW_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_t;

    // The last valid ring address rolls back to zero instead of running past the RAM depth.
    function automatic logic [CAP_AW_MAX-1:0] wrap_inc(input logic [CAP_AW_MAX-1:0] addr,
                                                      input logic [CAP_AW_MAX-1:0] last);
        wrap_inc = (addr == last) ? '0 : addr + CAP_AW_MAX'(1);
    endfunction

endpackage

// File: rtl/ring_addr_ctr.sv
// Ring write-address counter for the channel sample RAMs; wraps at ENTRIES-1.
module ring_addr_ctr
    import capture_pkg::*;
#(
    parameter int ENTRIES = 384,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] addr_next
);

    localparam logic [CAP_AW_MAX-1:0] LAST = CAP_AW_MAX'(ENTRIES - 1);

    // addr_next is also exported so the sequencer can name the slot after the final write.
    assign addr_next = AW'(wrap_inc(CAP_AW_MAX'(addr), LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (inc) begin
            addr <= addr_next;
        end
    end

endmodule

// File: rtl/capture_seq.sv
// Logic-analyzer capture sequencer: ring write, pre-trigger fill, post-trigger count.
// Optional CAPTURE_AUTO_REARM_EN adds auto_rearm to restart straight from DONE.
module capture_seq
    import capture_pkg::*;
#(
    parameter int ENTRIES = 384,
    parameter int AW      = $clog2(ENTRIES),
    parameter int NCH     = 5,
    parameter int TPW     = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic           capture_done,
    input  logic           wrt_smpl,
    input  logic           triggered,
    input  logic [TPW-1:0] trig_pos,
    input  logic [NCH-1:0] ch_en,
`ifdef CAPTURE_AUTO_REARM_EN
    input  logic           auto_rearm,
`endif
    output logic [NCH-1:0] we,
    output logic [AW-1:0]  waddr,
    output logic           armed,
    output logic           set_capture_done,
    output logic [AW-1:0]  trig_addr,
    output logic [AW-1:0]  rd_start,
    output logic           busy
);

    localparam logic [TPW-1:0] LAST_POS = TPW'(ENTRIES - 1);
    localparam logic [TPW:0]   DEPTH    = (TPW+1)'(ENTRIES);

    cap_state_t     state;
    cap_state_t     state_next;
    logic [TPW-1:0] tp_eff;
    logic [TPW:0]   pre_n;
    logic [TPW:0]   smpl_cnt;
    logic [TPW-1:0] trig_cnt;
    logic           sample_write;
    logic           restart;
    logic           trig_now;
    logic           tp_zero;
    logic           tp_one;
    logic           pre_fill_hit;
    logic           post_hit;
    logic [AW-1:0]  waddr_next;

    // One extra bit on the pre-fill target so a full ring (tp_eff = 0) is representable.
    assign tp_eff       = (trig_pos > LAST_POS) ? LAST_POS : trig_pos;
    assign pre_n        = DEPTH - {1'b0, tp_eff};
    assign tp_zero      = (tp_eff == '0);
    assign tp_one       = (tp_eff == TPW'(1));
    assign pre_fill_hit = ((smpl_cnt + (TPW+1)'(1)) == pre_n);
    assign post_hit     = (({1'b0, trig_cnt} + (TPW+1)'(1)) == {1'b0, tp_eff});
    assign trig_now     = (state == ST_ARMED) && run && triggered;
    assign restart      = (state_next == ST_PRE) && (state != ST_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (run && !capture_done) state_next = ST_PRE;
            end
            ST_PRE: begin
                if (!run)                              state_next = ST_IDLE;
                else if (sample_write && pre_fill_hit) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                // A trigger can finish the capture at once when no further samples are needed.
                if (!run)          state_next = ST_IDLE;
                else if (triggered) state_next = (tp_zero || (wrt_smpl && tp_one)) ? ST_DONE : ST_POST;
            end
            ST_POST: begin
                if (!run)                          state_next = ST_IDLE;
                else if (sample_write && post_hit) state_next = ST_DONE;
            end
            ST_DONE: begin
`ifdef CAPTURE_AUTO_REARM_EN
                if (!capture_done) state_next = (auto_rearm && run) ? ST_PRE : ST_IDLE;
`else
                if (!capture_done) state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin : output_decode
        sample_write     = 1'b0;
        busy             = 1'b0;
        set_capture_done = 1'b0;
        case (state)
            ST_PRE, ST_POST: begin
                busy         = 1'b1;
                sample_write = run && wrt_smpl;
            end
            ST_ARMED: begin
                busy         = 1'b1;
                sample_write = run && wrt_smpl && !(triggered && tp_zero);
            end
            default: begin
                busy         = 1'b0;
                sample_write = 1'b0;
            end
        endcase
        set_capture_done = (trig_now && (tp_zero || (wrt_smpl && tp_one)))
                         || ((state == ST_POST) && sample_write && post_hit);
        we = sample_write ? ch_en : '0;
    end

    ring_addr_ctr #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_waddr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (restart),
        .inc       (sample_write),
        .addr      (waddr),
        .addr_next (waddr_next)
    );

    // rd_start is the slot the next write would have used: past the final sample if one was written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_cnt  <= '0;
            trig_cnt  <= '0;
            armed     <= 1'b0;
            trig_addr <= '0;
            rd_start  <= '0;
        end else begin
            armed <= (state_next == ST_ARMED) || (state_next == ST_POST);
            if (restart) begin
                smpl_cnt <= '0;
                trig_cnt <= '0;
            end else begin
                if ((state == ST_PRE) && sample_write && (smpl_cnt != pre_n))
                    smpl_cnt <= smpl_cnt + (TPW+1)'(1);
                if (trig_now)
                    trig_cnt <= sample_write ? TPW'(1) : '0;
                else if ((state == ST_POST) && sample_write)
                    trig_cnt <= trig_cnt + TPW'(1);
            end
            if (trig_now)
                trig_addr <= waddr;
            if (set_capture_done)
                rd_start <= sample_write ? waddr_next : waddr;
        end
    end

endmodule
